// File: rtl/mux_scan_pkg.sv
// Shared constants and types for the 8:1 selector scan sequencer.
// The sequencer steps sel through every channel, so N_CH must stay 2**SEL_W.
package mux_scan_pkg;

  localparam int unsigned N_CH  = 8;
  localparam int unsigned SEL_W = 3;

  typedef enum logic [0:0] {
    IDLE,
    SCAN
  } scan_state_t;

  function automatic logic is_last_ch(input logic [SEL_W-1:0] s);
    return s == SEL_W'(N_CH - 1);
  endfunction

endpackage

// File: rtl/dwell_timer.sv
// Dwell counter: counts cycles a channel has been selected and flags the final one.
// The count only moves while en is high, so a hold freezes it without losing progress.
module dwell_timer #(
  parameter int unsigned DWELL = 4,
  parameter int unsigned CW    = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic last
);

  localparam logic [CW-1:0] LastCnt = CW'(DWELL - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign last = en && (cnt_q == LastCnt);

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = last ? '0 : cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mux_scan_ctrl.sv
// Sweeps the 8:1 selector through all channels, samples y at the end of each dwell
// and publishes the assembled byte atomically once per sweep.
module mux_scan_ctrl
  import mux_scan_pkg::*;
#(
  parameter int unsigned DWELL = 4,
  parameter int unsigned CW    = 16
) (
  input  logic             CLOCK_50,
  input  logic             RST,
  input  logic             start,
  input  logic             mode,
  input  logic             hold,
  input  logic             y,
  output logic [SEL_W-1:0] sel,
  output logic [N_CH-1:0]  sample,
  output logic             valid,
  output logic             busy
);

  scan_state_t      state_q, state_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [N_CH-1:0]  work_q, work_d;
  logic [N_CH-1:0]  sample_q, sample_d;
  logic             valid_q, valid_d;
  logic             mode_q, mode_d;

  logic timer_en;
  logic timer_clr;
  logic last;

  assign timer_en  = (state_q == SCAN) && !hold;
  assign timer_clr = (state_q == IDLE);

  dwell_timer #(
    .DWELL(DWELL),
    .CW   (CW)
  ) u_dwell_timer (
    .clk (CLOCK_50),
    .rst (RST),
    .en  (timer_en),
    .clr (timer_clr),
    .last(last)
  );

  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    work_d   = work_q;
    sample_d = sample_q;
    mode_d   = mode_q;
    valid_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        sel_d = '0;
        if (start) begin
          state_d = SCAN;
          mode_d  = mode;
        end
      end
      SCAN: begin
        if (last) begin
          work_d[sel_q] = y;
          if (is_last_ch(sel_q)) begin
            // Bit 7 comes straight from y so the byte is complete on this edge.
            sample_d = {y, work_q[N_CH-2:0]};
            valid_d  = 1'b1;
            sel_d    = '0;
            mode_d   = mode;
            state_d  = (mode_q && mode) ? SCAN : IDLE;
          end else begin
            sel_d = sel_q + SEL_W'(1);
          end
        end
      end
    endcase
  end

  always_ff @(posedge CLOCK_50 or posedge RST) begin
    if (RST) begin
      state_q  <= IDLE;
      sel_q    <= '0;
      work_q   <= '0;
      sample_q <= '0;
      valid_q  <= 1'b0;
      mode_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      work_q   <= work_d;
      sample_q <= sample_d;
      valid_q  <= valid_d;
      mode_q   <= mode_d;
    end
  end

  assign sel    = sel_q;
  assign sample = sample_q;
  assign valid  = valid_q;
  assign busy   = (state_q == SCAN);

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Bench for mux_scan_ctrl: behavioural 8:1 selectors drive y for a DWELL=4 and a DWELL=1 instance.
module tb_mux_scan_ctrl;

  logic       CLOCK_50 = 1'b0;
  logic       RST = 1'b1;
  logic       start = 1'b0, mode = 1'b0, hold = 1'b0;
  logic [7:0] din = 8'h00;
  logic       y;
  logic [2:0] sel;
  logic [7:0] sample;
  logic       valid, busy;

  logic       start1 = 1'b0, mode1 = 1'b0, hold1 = 1'b0;
  logic [7:0] din1 = 8'h00;
  logic       y1;
  logic [2:0] sel1;
  logic [7:0] sample1;
  logic       valid1, busy1;

  int vectors = 0;
  int miscompares = 0;
  logic [7:0] exp_q[$];
  logic [7:0] exp1_q[$];

  assign y  = din[sel];
  assign y1 = din1[sel1];

  always #10 CLOCK_50 = ~CLOCK_50;

  mux_scan_ctrl #(.DWELL(4), .CW(16)) dut (
    .CLOCK_50(CLOCK_50), .RST(RST), .start(start), .mode(mode), .hold(hold), .y(y),
    .sel(sel), .sample(sample), .valid(valid), .busy(busy)
  );

  mux_scan_ctrl #(.DWELL(1), .CW(4)) dut1 (
    .CLOCK_50(CLOCK_50), .RST(RST), .start(start1), .mode(mode1), .hold(hold1), .y(y1),
    .sel(sel1), .sample(sample1), .valid(valid1), .busy(busy1)
  );

  task automatic step();
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic wait_valid(input int bound, output int k);
    k = -1;
    for (int i = 1; i <= bound; i++) begin
      step();
      if (valid === 1'b1) begin
        k = i;
        break;
      end
    end
  endtask

  task automatic wait_valid1(input int bound, output int k);
    k = -1;
    for (int i = 1; i <= bound; i++) begin
      step();
      if (valid1 === 1'b1) begin
        k = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    #25;
    vectors++;
    if (sel !== 3'd0 || sample !== 8'h00 || valid !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_state: sel=%0d sample=%h valid=%b busy=%b, want 0/00/0/0",
               sel, sample, valid, busy);
    end
    vectors++;
    if (sel1 !== 3'd0 || sample1 !== 8'h00 || valid1 !== 1'b0 || busy1 !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_state_d1: sel=%0d sample=%h valid=%b busy=%b, want 0/00/0/0",
               sel1, sample1, valid1, busy1);
    end
    @(negedge CLOCK_50);
    RST = 1'b0;
    step();
  endtask

  task automatic test_single();
    logic [7:0] e;
    din = 8'hA5; mode = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    exp_q.push_back(8'hA5);
    vectors++;
    if (busy !== 1'b1 || sel !== 3'd0) begin
      miscompares++;
      $display("FAIL single_start: busy=%b sel=%0d, want 1/0", busy, sel);
    end
    for (int k = 1; k <= 31; k++) begin
      step();
      vectors++;
      if (sel !== 3'(k / 4) || valid !== 1'b0) begin
        miscompares++;
        $display("FAIL single_sel k=%0d: sel=%0d valid=%b, want %0d/0", k, sel, valid, k / 4);
      end
    end
    step();
    e = exp_q.pop_front();
    vectors++;
    if (valid !== 1'b1 || sample !== e || busy !== 1'b0 || sel !== 3'd0) begin
      miscompares++;
      $display("FAIL single_done: valid=%b sample=%h busy=%b sel=%0d, want 1/%h/0/0",
               valid, sample, busy, sel, e);
    end
    step();
    vectors++;
    if (valid !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL single_pulse: valid=%b busy=%b, want 0/0", valid, busy);
    end
  endtask

  task automatic test_continuous();
    int k;
    logic [7:0] e;
    din = 8'h3C; mode = 1'b1; start = 1'b1;
    step();
    start = 1'b0;
    exp_q.push_back(8'hC4);
    exp_q.push_back(8'hC3);
    exp_q.push_back(8'hC3);
    repeat (12) step();
    vectors++;
    if (sel !== 3'd3) begin
      miscompares++;
      $display("FAIL cont_sel12: sel=%0d, want 3", sel);
    end
    // Channel 2 has just been captured from 8'h3C; the rest of sweep 1 sees 8'hC3.
    din = 8'hC3;
    wait_valid(40, k);
    e = exp_q.pop_front();
    vectors++;
    if (k !== 20 || sample !== e || sel !== 3'd0 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL cont_sweep1: k=%0d sample=%h sel=%0d busy=%b, want 20/%h/0/1",
               k, sample, sel, busy, e);
    end
    wait_valid(40, k);
    e = exp_q.pop_front();
    vectors++;
    if (k !== 32 || sample !== e || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL cont_sweep2: k=%0d sample=%h busy=%b, want 32/%h/1", k, sample, busy, e);
    end
    repeat (10) step();
    mode = 1'b0;
    wait_valid(40, k);
    e = exp_q.pop_front();
    vectors++;
    if (k !== 22 || sample !== e || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL cont_sweep3: k=%0d sample=%h busy=%b, want 22/%h/0", k, sample, busy, e);
    end
    wait_valid(40, k);
    vectors++;
    if (k !== -1 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL cont_stop: extra valid k=%0d busy=%b, want none/0", k, busy);
    end
  endtask

  task automatic test_hold();
    int k;
    logic [7:0] e;
    din = 8'h5A; mode = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    exp_q.push_back(8'h5A);
    repeat (14) step();
    vectors++;
    if (sel !== 3'd3) begin
      miscompares++;
      $display("FAIL hold_pre: sel=%0d, want 3", sel);
    end
    // Wrong data while frozen: any capture during hold would corrupt the byte.
    hold = 1'b1; din = 8'hA5;
    for (int i = 1; i <= 5; i++) begin
      step();
      vectors++;
      if (sel !== 3'd3 || valid !== 1'b0) begin
        miscompares++;
        $display("FAIL hold_frozen i=%0d: sel=%0d valid=%b, want 3/0", i, sel, valid);
      end
    end
    hold = 1'b0; din = 8'h5A;
    wait_valid(40, k);
    e = exp_q.pop_front();
    vectors++;
    if (k !== 18 || sample !== e) begin
      miscompares++;
      $display("FAIL hold_done: k=%0d sample=%h, want 18/%h", k, sample, e);
    end
  endtask

  task automatic test_reset_mid();
    int k;
    logic [7:0] e;
    din = 8'h3C; mode = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    repeat (20) step();
    vectors++;
    if (sel !== 3'd5) begin
      miscompares++;
      $display("FAIL rstmid_pre: sel=%0d, want 5", sel);
    end
    #3 RST = 1'b1;
    #1;
    vectors++;
    if (sel !== 3'd0 || sample !== 8'h00 || valid !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL rstmid_async: sel=%0d sample=%h valid=%b busy=%b, want 0/00/0/0",
               sel, sample, valid, busy);
    end
    @(negedge CLOCK_50);
    RST = 1'b0;
    din = 8'h69; start = 1'b1;
    step();
    start = 1'b0;
    exp_q.push_back(8'h69);
    wait_valid(40, k);
    e = exp_q.pop_front();
    vectors++;
    if (k !== 32 || sample !== e) begin
      miscompares++;
      $display("FAIL rstmid_resweep: k=%0d sample=%h, want 32/%h", k, sample, e);
    end
  endtask

  task automatic test_start_ignored();
    int k;
    logic [7:0] e;
    din = 8'h96; mode = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    exp_q.push_back(8'h96);
    repeat (16) step();
    vectors++;
    if (sel !== 3'd4) begin
      miscompares++;
      $display("FAIL restart_pre: sel=%0d, want 4", sel);
    end
    start = 1'b1;
    step();
    start = 1'b0;
    wait_valid(40, k);
    e = exp_q.pop_front();
    vectors++;
    if (k !== 15 || sample !== e || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL restart_done: k=%0d sample=%h busy=%b, want 15/%h/0", k, sample, busy, e);
    end
    wait_valid(40, k);
    vectors++;
    if (k !== -1 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL restart_extra: k=%0d busy=%b, want none/0", k, busy);
    end
  endtask

  task automatic test_dwell1();
    int k;
    logic [7:0] e;
    din1 = 8'h81; mode1 = 1'b1; start1 = 1'b1;
    step();
    start1 = 1'b0;
    repeat (3) exp1_q.push_back(8'h81);
    for (int i = 1; i <= 7; i++) begin
      step();
      vectors++;
      if (sel1 !== 3'(i) || valid1 !== 1'b0) begin
        miscompares++;
        $display("FAIL d1_sel i=%0d: sel=%0d valid=%b, want %0d/0", i, sel1, valid1, i);
      end
    end
    step();
    e = exp1_q.pop_front();
    vectors++;
    if (valid1 !== 1'b1 || sample1 !== e || sel1 !== 3'd0) begin
      miscompares++;
      $display("FAIL d1_sweep1: valid=%b sample=%h sel=%0d, want 1/%h/0", valid1, sample1, sel1, e);
    end
    step();
    vectors++;
    if (valid1 !== 1'b0 || sel1 !== 3'd1) begin
      miscompares++;
      $display("FAIL d1_gap: valid=%b sel=%0d, want 0/1", valid1, sel1);
    end
    wait_valid1(20, k);
    e = exp1_q.pop_front();
    vectors++;
    if (k !== 7 || sample1 !== e || busy1 !== 1'b1) begin
      miscompares++;
      $display("FAIL d1_sweep2: k=%0d sample=%h busy=%b, want 7/%h/1", k, sample1, busy1, e);
    end
    mode1 = 1'b0;
    wait_valid1(20, k);
    e = exp1_q.pop_front();
    vectors++;
    if (k !== 8 || sample1 !== e || busy1 !== 1'b0) begin
      miscompares++;
      $display("FAIL d1_sweep3: k=%0d sample=%h busy=%b, want 8/%h/0", k, sample1, busy1, e);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single();
    test_continuous();
    test_hold();
    test_reset_mid();
    test_start_ignored();
    test_dwell1();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
